channel_sched: RTL and testbench
================================

CHANNEL_SCHED -- requirements
Module: channel_sched

Interface
REQ-001 Parameter SYM_W, default 8: symbol width in bits.
REQ-002 Parameter CW_LEN, default 15: symbols per codeword, 2..255.
REQ-003 clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_sym  input  SYM_W  symbol to transmit.
REQ-006 in_valid  input  1  in_sym valid.
REQ-007 in_ready  output  1  block accepts in_sym this cycle.
REQ-008 err_level  input  3  error level applied inside the error window, 0..7.
REQ-009 err_start  input  8  first symbol index of the error window within a codeword.
REQ-010 err_len  input  8  window length in symbols; 0 disables injection.
REQ-011 ch_data  output  1  serial bit to channel data input.
REQ-012 ch_num_errors  output  3  error level to channel.
REQ-013 ch_rx  input  1  serial bit returned by channel, registered one cycle after ch_data.
REQ-014 out_sym  output  SYM_W  reassembled received symbol.
REQ-015 out_valid  output  1  one-cycle pulse, out_sym valid; no backpressure.
REQ-016 out_last  output  1  with out_valid, last symbol of a codeword.
REQ-017 busy  output  1  transmit or receive in progress.
REQ-018 cw_count  output  16  received codewords completed, wraps at 2^16.

Function
REQ-019 TX FSM states: IDLE, SHIFT; in_ready = 1 in IDLE and in SHIFT when bit_cnt == SYM_W-1, else 0.
REQ-020 Accept = in_valid & in_ready; loads shift register, bit_cnt = 0, enters/stays SHIFT.
REQ-021 In SHIFT, ch_data drives bits MSB first, one bit per cycle, SYM_W cycles per symbol; cycle t accept gives bits on t+1..t+SYM_W.
REQ-022 SHIFT with bit_cnt == SYM_W-1 and no accept returns to IDLE; with accept continues gap-free.
REQ-023 In IDLE, ch_data = 0 and ch_num_errors = 0.
REQ-024 TX symbol index tx_idx increments on each accept, wraps CW_LEN-1 -> 0.
REQ-025 err_level, err_start, err_len captured on accept with tx_idx == 0; held for the whole codeword.
REQ-026 ch_num_errors = captured level for all bits of a symbol with err_start <= tx_idx < err_start+err_len (9-bit sum, no wrap), else 0.
REQ-027 A 1-bit tx-valid flag, delayed one cycle, qualifies ch_rx; RX shifts qualified bits MSB first.
REQ-028 After SYM_W qualified bits, out_sym/out_valid asserted next cycle; accept at t gives out_valid at t+SYM_W+2.
REQ-029 RX index rx_idx increments per out_valid, wraps CW_LEN-1 -> 0; out_last = out_valid & (rx_idx == CW_LEN-1).
REQ-030 cw_count increments on each out_last.
REQ-031 busy = (TX state != IDLE) or RX holds a partial symbol or out_valid pending.
REQ-032 in_valid deasserted mid-codeword: tx_idx/rx_idx retained; codeword resumes on next accept.

Reset
REQ-033 rst_n low: TX to IDLE, shift registers, bit_cnt, tx_idx, rx_idx, captured config, cw_count cleared to 0.
REQ-034 Reset outputs: in_ready 1 after release, ch_data 0, ch_num_errors 0, out_sym 0, out_valid 0, out_last 0, busy 0.
REQ-035 Reset mid-symbol discards partial TX and RX symbols; no out_valid for them.

Verification
REQ-036 SYM_W=8, single accept 0xA5, err_len=0, channel modelled as 1-cycle register -> ch_data 1,0,1,0,0,1,0,1; out_sym 0xA5 at t+10; ch_num_errors 0 throughout.
REQ-037 15 back-to-back symbols 0x00..0x0E, in_valid held -> in_ready every 8th cycle, no ch_data gap, 15 out_valid, out_last on 0x0E, cw_count = 1.
REQ-038 err_level=7, err_start=3, err_len=2 -> ch_num_errors = 7 only during bits of tx_idx 3 and 4, 0 elsewhere; config changed mid-codeword has no effect until next tx_idx 0.
REQ-039 err_start=250, err_len=10, CW_LEN=255 -> window tx_idx 250..254 only, no wrap into index 0..4.
REQ-040 rst_n pulsed low at bit 4 of symbol 2 -> all outputs to reset values immediately, no out_valid for partial symbol, next codeword starts at tx_idx 0.
REQ-041 in_valid gap of 20 cycles after symbol 5 -> FSM IDLE, busy falls after last out_valid, symbol 6 gets tx_idx 6.

Source files
------------

// File: rtl/channel_sched.sv
// Serialises symbols MSB-first onto a 1-bit channel with a per-codeword error window,
// and reassembles the bits the channel returns one cycle later into received symbols.
module channel_sched #(
    parameter int SYM_W  = 8,
    parameter int CW_LEN = 15
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [SYM_W-1:0] in_sym,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       err_level,
    input  logic [7:0]       err_start,
    input  logic [7:0]       err_len,
    output logic             ch_data,
    output logic [2:0]       ch_num_errors,
    input  logic             ch_rx,
    output logic [SYM_W-1:0] out_sym,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy,
    output logic [15:0]      cw_count
);
    localparam int CNT_W = (SYM_W > 1) ? $clog2(SYM_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SYM_W - 1);
    localparam logic [7:0]       LAST_IDX = 8'(CW_LEN - 1);

    typedef enum logic {IDLE, SHIFT} tx_state_t;

    tx_state_t        state_q, state_d;
    logic [SYM_W-1:0] tx_sh_q, tx_sh_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       tx_idx_q, tx_idx_d;
    logic [2:0]       lvl_q, lvl_d;
    logic [7:0]       start_q, start_d;
    logic [7:0]       len_q, len_d;
    logic [2:0]       sym_err_q, sym_err_d;

    logic             rx_v_q, rx_v_d;
    logic [SYM_W-1:0] rx_sh_q, rx_sh_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [7:0]       rx_idx_q, rx_idx_d;
    logic [SYM_W-1:0] out_sym_q, out_sym_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [15:0]      cw_count_q, cw_count_d;

    logic       sym_end, accept, first_sym, in_win;
    logic [2:0] use_lvl;
    logic [7:0] use_start, use_len;
    logic [8:0] win_end;

    // The first symbol of a codeword sees the live config, later symbols the captured one.
    always_comb begin
        sym_end   = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
        in_ready  = (state_q == IDLE) || sym_end;
        accept    = in_valid && in_ready;
        first_sym = (tx_idx_q == 8'd0);
        use_lvl   = first_sym ? err_level : lvl_q;
        use_start = first_sym ? err_start : start_q;
        use_len   = first_sym ? err_len   : len_q;
        win_end   = {1'b0, use_start} + {1'b0, use_len};
        in_win    = ({1'b0, tx_idx_q} >= {1'b0, use_start}) && ({1'b0, tx_idx_q} < win_end);
    end

    always_comb begin
        state_d   = state_q;
        tx_sh_d   = tx_sh_q;
        bit_cnt_d = bit_cnt_q;
        tx_idx_d  = tx_idx_q;
        lvl_d     = lvl_q;
        start_d   = start_q;
        len_d     = len_q;
        sym_err_d = sym_err_q;
        if (accept) begin
            state_d   = SHIFT;
            tx_sh_d   = in_sym;
            bit_cnt_d = '0;
            tx_idx_d  = (tx_idx_q == LAST_IDX) ? 8'd0 : tx_idx_q + 8'd1;
            sym_err_d = in_win ? use_lvl : 3'd0;
            if (first_sym) begin
                lvl_d   = err_level;
                start_d = err_start;
                len_d   = err_len;
            end
        end else if (state_q == SHIFT) begin
            if (sym_end) begin
                state_d = IDLE;
            end else begin
                tx_sh_d   = tx_sh_q << 1;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    // rx_v_q marks the cycle in which ch_rx carries a transmitted bit.
    always_comb begin
        rx_v_d      = (state_q == SHIFT);
        rx_sh_d     = rx_sh_q;
        rx_cnt_d    = rx_cnt_q;
        rx_idx_d    = rx_idx_q;
        out_sym_d   = out_sym_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        cw_count_d  = cw_count_q;
        if (rx_v_q) begin
            rx_sh_d = (rx_sh_q << 1) | SYM_W'(ch_rx);
            if (rx_cnt_q == LAST_BIT) begin
                rx_cnt_d    = '0;
                out_valid_d = 1'b1;
                out_sym_d   = rx_sh_d;
                out_last_d  = (rx_idx_q == LAST_IDX);
                rx_idx_d    = (rx_idx_q == LAST_IDX) ? 8'd0 : rx_idx_q + 8'd1;
                if (rx_idx_q == LAST_IDX) begin
                    cw_count_d = cw_count_q + 16'd1;
                end
            end else begin
                rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_sh_q     <= '0;
            bit_cnt_q   <= '0;
            tx_idx_q    <= '0;
            lvl_q       <= '0;
            start_q     <= '0;
            len_q       <= '0;
            sym_err_q   <= '0;
            rx_v_q      <= 1'b0;
            rx_sh_q     <= '0;
            rx_cnt_q    <= '0;
            rx_idx_q    <= '0;
            out_sym_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            cw_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            tx_sh_q     <= tx_sh_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_idx_q    <= tx_idx_d;
            lvl_q       <= lvl_d;
            start_q     <= start_d;
            len_q       <= len_d;
            sym_err_q   <= sym_err_d;
            rx_v_q      <= rx_v_d;
            rx_sh_q     <= rx_sh_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_idx_q    <= rx_idx_d;
            out_sym_q   <= out_sym_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            cw_count_q  <= cw_count_d;
        end
    end

    assign ch_data       = (state_q == SHIFT) && tx_sh_q[SYM_W-1];
    assign ch_num_errors = (state_q == SHIFT) ? sym_err_q : 3'd0;
    assign out_sym       = out_sym_q;
    assign out_valid     = out_valid_q;
    assign out_last      = out_last_q;
    assign cw_count      = cw_count_q;
    assign busy          = (state_q != IDLE) || rx_v_q || (rx_cnt_q != '0) || out_valid_q;

endmodule

// File: tb/tb_channel_sched.sv
// Directed bench for channel_sched: one 15-symbol-codeword instance and one 255-symbol instance,
// each looped through a one-cycle channel register.
module tb_channel_sched;
    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic       rst_n = 1'b1;
    logic [7:0] in_sym = '0;
    logic       in_valid_a = 1'b0, in_valid_b = 1'b0;
    logic [2:0] err_level = '0;
    logic [7:0] err_start = '0, err_len = '0;

    logic in_ready_a, ch_data_a, out_valid_a, out_last_a, busy_a;
    logic in_ready_b, ch_data_b, out_valid_b, out_last_b, busy_b;
    logic [2:0] nerr_a, nerr_b;
    logic [7:0] out_sym_a, out_sym_b;
    logic [15:0] cw_count_a, cw_count_b;
    logic ch_rx_a = 1'b0, ch_rx_b = 1'b0;

    channel_sched #(.SYM_W(8), .CW_LEN(15)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .in_sym(in_sym), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .err_level(err_level), .err_start(err_start), .err_len(err_len),
        .ch_data(ch_data_a), .ch_num_errors(nerr_a), .ch_rx(ch_rx_a),
        .out_sym(out_sym_a), .out_valid(out_valid_a), .out_last(out_last_a),
        .busy(busy_a), .cw_count(cw_count_a));

    channel_sched #(.SYM_W(8), .CW_LEN(255)) dut_long (
        .clk_in(clk_in), .rst_n(rst_n), .in_sym(in_sym), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .err_level(err_level), .err_start(err_start), .err_len(err_len),
        .ch_data(ch_data_b), .ch_num_errors(nerr_b), .ch_rx(ch_rx_b),
        .out_sym(out_sym_b), .out_valid(out_valid_b), .out_last(out_last_b),
        .busy(busy_b), .cw_count(cw_count_b));

    // Channel: one-cycle register from ch_data back to ch_rx.
    always @(posedge clk_in) begin
        ch_rx_a <= ch_data_a;
        ch_rx_b <= ch_data_b;
    end

    int cyc = 0;
    always @(posedge clk_in) cyc++;

    logic [7:0] mon_sym[$];
    logic       mon_last[$];
    int         mon_cyc[$];
    always @(negedge clk_in) begin
        if (out_valid_a === 1'b1) begin
            mon_sym.push_back(out_sym_a);
            mon_last.push_back(out_last_a);
            mon_cyc.push_back(cyc);
        end
    end

    int checks = 0;
    int failures = 0;

    logic [7:0] tx_syms [256];
    logic       obs_bit [256][8];
    logic [2:0] obs_nerr[256][8];
    logic       obs_rdy0[256];
    logic       obs_rdymid[256][8];
    logic       obs_to[256];
    int         acc_cyc[256];
    logic [2:0] cfg2_lvl = '0;
    logic [7:0] cfg2_start = '0, cfg2_len = '0;

    // Stimulus only: present n symbols back-to-back and record what the channel side shows.
    task automatic send(input int n, input bit sel, input int chg_k);
        int w;
        for (int k = 0; k < n; k++) begin
            if (k == chg_k) begin
                err_level = cfg2_lvl; err_start = cfg2_start; err_len = cfg2_len;
            end
            in_sym = tx_syms[k];
            if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
            obs_rdy0[k] = sel ? in_ready_b : in_ready_a;
            w = 0;
            while ((sel ? in_ready_b : in_ready_a) !== 1'b1 && w < 20) begin
                @(negedge clk_in);
                w++;
            end
            obs_to[k] = (w >= 20);
            acc_cyc[k] = cyc;
            for (int b = 0; b < 8; b++) begin
                @(negedge clk_in);
                obs_bit[k][b]    = sel ? ch_data_b : ch_data_a;
                obs_nerr[k][b]   = sel ? nerr_b : nerr_a;
                obs_rdymid[k][b] = sel ? in_ready_b : in_ready_a;
            end
            if (k == n - 1) begin
                in_valid_a = 1'b0; in_valid_b = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        @(negedge clk_in);
        rst_n = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        #1;
        mon_sym.delete(); mon_last.delete(); mon_cyc.delete();
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        rst_n = 1'b0;
        #1;
        checks++; if (ch_data_a !== 1'b0) begin failures++; $display("FAIL rst_ch_data got=%0b exp=0", ch_data_a); end
        checks++; if (nerr_a !== 3'd0) begin failures++; $display("FAIL rst_nerr got=%0d exp=0", nerr_a); end
        checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid_a); end
        checks++; if (out_last_a !== 1'b0) begin failures++; $display("FAIL rst_out_last got=%0b exp=0", out_last_a); end
        checks++; if (out_sym_a !== 8'h00) begin failures++; $display("FAIL rst_out_sym got=%0h exp=0", out_sym_a); end
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        #1;
        checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy_a); end
        checks++; if (cw_count_a !== 16'd0) begin failures++; $display("FAIL rst_cw_count got=%0d exp=0", cw_count_a); end
        checks++; if (in_ready_b !== 1'b1 || busy_b !== 1'b0) begin failures++; $display("FAIL rst_long rdy=%0b busy=%0b exp=1/0", in_ready_b, busy_b); end
    endtask

    task automatic test_single();
        logic [7:0] expb;
        int w;
        $display("test_single: accept 0xA5");
        do_reset();
        err_level = 3'd7; err_start = 8'd0; err_len = 8'd0;
        tx_syms[0] = 8'hA5;
        expb = 8'b10100101;
        @(negedge clk_in);
        send(1, 1'b0, -1);
        for (int b = 0; b < 8; b++) begin
            checks++; if (obs_bit[0][b] !== expb[7-b]) begin failures++; $display("FAIL single_bit b=%0d got=%0b exp=%0b", b, obs_bit[0][b], expb[7-b]); end
            checks++; if (obs_nerr[0][b] !== 3'd0) begin failures++; $display("FAIL single_nerr b=%0d got=%0d exp=0", b, obs_nerr[0][b]); end
        end
        w = 0;
        while (mon_sym.size() < 1 && w < 20) begin @(negedge clk_in); #1; w++; end
        checks++; if (mon_sym.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", mon_sym.size()); end
        if (mon_sym.size() >= 1) begin
            checks++; if (mon_sym[0] !== 8'hA5) begin failures++; $display("FAIL single_sym got=%0h exp=a5", mon_sym[0]); end
            checks++; if (mon_cyc[0] - acc_cyc[0] != 10) begin failures++; $display("FAIL single_latency got=%0d exp=10", mon_cyc[0] - acc_cyc[0]); end
            checks++; if (mon_last[0] !== 1'b0) begin failures++; $display("FAIL single_last got=%0b exp=0", mon_last[0]); end
            @(negedge clk_in); #1;
            checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%0b exp=0", busy_a); end
        end
    endtask

    task automatic test_back_to_back();
        int w;
        $display("test_back_to_back: 15 symbols 0x00..0x0E");
        do_reset();
        err_len = 8'd0;
        for (int k = 0; k < 15; k++) tx_syms[k] = 8'(k);
        @(negedge clk_in);
        send(15, 1'b0, -1);
        for (int k = 0; k < 15; k++) begin
            checks++; if (obs_rdy0[k] !== 1'b1 || obs_to[k] !== 1'b0) begin failures++; $display("FAIL b2b_ready k=%0d got=%0b exp=1", k, obs_rdy0[k]); end
            for (int b = 0; b < 8; b++) begin
                checks++; if (obs_bit[k][b] !== tx_syms[k][7-b]) begin failures++; $display("FAIL b2b_bit k=%0d b=%0d got=%0b exp=%0b", k, b, obs_bit[k][b], tx_syms[k][7-b]); end
                checks++; if (obs_rdymid[k][b] !== (b == 7)) begin failures++; $display("FAIL b2b_rdymid k=%0d b=%0d got=%0b exp=%0b", k, b, obs_rdymid[k][b], (b == 7)); end
            end
        end
        w = 0;
        while (mon_sym.size() < 15 && w < 30) begin @(negedge clk_in); #1; w++; end
        checks++; if (mon_sym.size() != 15) begin failures++; $display("FAIL b2b_count got=%0d exp=15", mon_sym.size()); end
        for (int k = 0; k < 15 && k < mon_sym.size(); k++) begin
            checks++; if (mon_sym[k] !== 8'(k) || mon_last[k] !== (k == 14)) begin failures++; $display("FAIL b2b_rx k=%0d sym=%0h last=%0b exp=%0h/%0b", k, mon_sym[k], mon_last[k], k, (k == 14)); end
            if (k > 0) begin
                checks++; if (mon_cyc[k] - mon_cyc[k-1] != 8) begin failures++; $display("FAIL b2b_rx_spacing k=%0d got=%0d exp=8", k, mon_cyc[k] - mon_cyc[k-1]); end
            end
        end
        checks++; if (cw_count_a !== 16'd1) begin failures++; $display("FAIL b2b_cw_count got=%0d exp=1", cw_count_a); end
    endtask

    task automatic test_err_window();
        logic [2:0] e;
        $display("test_err_window: level 7 start 3 len 2, config changed at symbol 5");
        do_reset();
        err_level = 3'd7; err_start = 8'd3; err_len = 8'd2;
        cfg2_lvl = 3'd5; cfg2_start = 8'd0; cfg2_len = 8'd15;
        for (int k = 0; k < 16; k++) tx_syms[k] = 8'h30 + 8'(k);
        @(negedge clk_in);
        send(16, 1'b0, 5);
        for (int k = 0; k < 16; k++) begin
            e = (k == 15) ? 3'd5 : ((k == 3 || k == 4) ? 3'd7 : 3'd0);
            for (int b = 0; b < 8; b++) begin
                checks++; if (obs_nerr[k][b] !== e) begin failures++; $display("FAIL errwin_nerr k=%0d b=%0d got=%0d exp=%0d", k, b, obs_nerr[k][b], e); end
            end
        end
        @(negedge clk_in);
        checks++; if (nerr_a !== 3'd0) begin failures++; $display("FAIL errwin_idle_nerr got=%0d exp=0", nerr_a); end
    endtask

    task automatic test_long_codeword();
        logic [2:0] e;
        int w;
        $display("test_long_codeword: CW_LEN 255, start 250 len 10");
        do_reset();
        err_level = 3'd4; err_start = 8'd250; err_len = 8'd10;
        for (int k = 0; k < 255; k++) tx_syms[k] = 8'(k);
        @(negedge clk_in);
        send(255, 1'b1, -1);
        for (int k = 0; k < 255; k++) begin
            e = (k >= 250) ? 3'd4 : 3'd0;
            for (int b = 0; b < 8; b++) begin
                checks++; if (obs_nerr[k][b] !== e) begin failures++; $display("FAIL long_nerr k=%0d b=%0d got=%0d exp=%0d", k, b, obs_nerr[k][b], e); end
            end
        end
        w = 0;
        while (busy_b === 1'b1 && w < 20) begin @(negedge clk_in); w++; end
        checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL long_busy got=%0b exp=0", busy_b); end
        checks++; if (cw_count_b !== 16'd1) begin failures++; $display("FAIL long_cw_count got=%0d exp=1", cw_count_b); end
    endtask

    task automatic test_reset_mid();
        int n0, w;
        $display("test_reset_mid: reset at bit 4 of symbol 2");
        do_reset();
        err_len = 8'd0;
        tx_syms[0] = 8'h11; tx_syms[1] = 8'h22;
        @(negedge clk_in);
        send(2, 1'b0, -1);
        in_sym = 8'h33; in_valid_a = 1'b1;
        for (int b = 0; b < 5; b++) @(negedge clk_in);
        in_valid_a = 1'b0;
        n0 = mon_sym.size();
        rst_n = 1'b0;
        #1;
        checks++; if (ch_data_a !== 1'b0 || nerr_a !== 3'd0) begin failures++; $display("FAIL rstmid_ch got=%0b/%0d exp=0/0", ch_data_a, nerr_a); end
        checks++; if (busy_a !== 1'b0 || out_valid_a !== 1'b0 || out_last_a !== 1'b0) begin failures++; $display("FAIL rstmid_flags busy=%0b ov=%0b ol=%0b exp=0", busy_a, out_valid_a, out_last_a); end
        checks++; if (out_sym_a !== 8'h00 || cw_count_a !== 16'd0) begin failures++; $display("FAIL rstmid_data sym=%0h cw=%0d exp=0/0", out_sym_a, cw_count_a); end
        checks++; if (n0 != 2) begin failures++; $display("FAIL rstmid_pre_count got=%0d exp=2", n0); end
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin @(negedge clk_in); #1; end
        checks++; if (mon_sym.size() != n0) begin failures++; $display("FAIL rstmid_no_partial got=%0d exp=%0d", mon_sym.size(), n0); end
        checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%0b exp=1", in_ready_a); end
        for (int k = 0; k < 15; k++) tx_syms[k] = 8'h40 + 8'(k);
        @(negedge clk_in);
        send(15, 1'b0, -1);
        w = 0;
        while (mon_sym.size() < n0 + 15 && w < 30) begin @(negedge clk_in); #1; w++; end
        checks++; if (mon_sym.size() != n0 + 15) begin failures++; $display("FAIL rstmid_count got=%0d exp=%0d", mon_sym.size(), n0 + 15); end
        for (int k = 0; k < 15 && n0 + k < mon_sym.size(); k++) begin
            checks++; if (mon_sym[n0+k] !== tx_syms[k] || mon_last[n0+k] !== (k == 14)) begin failures++; $display("FAIL rstmid_rx k=%0d sym=%0h last=%0b exp=%0h/%0b", k, mon_sym[n0+k], mon_last[n0+k], tx_syms[k], (k == 14)); end
        end
        checks++; if (cw_count_a !== 16'd1) begin failures++; $display("FAIL rstmid_cw_count got=%0d exp=1", cw_count_a); end
    endtask

    task automatic test_gap();
        int n0, w, nv, iv;
        logic gb[21];
        logic gv[21];
        $display("test_gap: 20-cycle in_valid gap after symbol 5");
        do_reset();
        err_level = 3'd3; err_start = 8'd6; err_len = 8'd1;
        for (int k = 0; k < 6; k++) tx_syms[k] = 8'h50 + 8'(k);
        @(negedge clk_in);
        send(6, 1'b0, -1);
        for (int k = 0; k < 6; k++) begin
            checks++; if (obs_nerr[k][0] !== 3'd0) begin failures++; $display("FAIL gap_first_nerr k=%0d got=%0d exp=0", k, obs_nerr[k][0]); end
        end
        nv = 0; iv = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_in); #1;
            gb[i] = busy_a; gv[i] = out_valid_a;
            if (out_valid_a === 1'b1) begin nv++; iv = i; end
        end
        checks++; if (nv != 1 || iv != 2) begin failures++; $display("FAIL gap_last_out_valid count=%0d at=%0d exp=1/2", nv, iv); end
        if (iv >= 1 && iv < 20) begin
            checks++; if (gb[iv] !== 1'b1 || gb[iv+1] !== 1'b0) begin failures++; $display("FAIL gap_busy_fall got=%0b%0b exp=10", gb[iv], gb[iv+1]); end
        end
        checks++; if (in_ready_a !== 1'b1 || ch_data_a !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL gap_idle rdy=%0b data=%0b busy=%0b exp=1/0/0", in_ready_a, ch_data_a, busy_a); end
        n0 = mon_sym.size();
        for (int k = 0; k < 9; k++) tx_syms[k] = 8'h56 + 8'(k);
        @(negedge clk_in);
        send(9, 1'b0, -1);
        for (int k = 0; k < 9; k++) begin
            checks++; if (obs_nerr[k][3] !== ((k == 0) ? 3'd3 : 3'd0)) begin failures++; $display("FAIL gap_resume_nerr k=%0d got=%0d exp=%0d", k, obs_nerr[k][3], (k == 0) ? 3 : 0); end
        end
        w = 0;
        while (mon_sym.size() < n0 + 9 && w < 30) begin @(negedge clk_in); #1; w++; end
        checks++; if (mon_sym.size() != n0 + 9 || n0 != 6) begin failures++; $display("FAIL gap_count got=%0d+%0d exp=6+9", n0, mon_sym.size() - n0); end
        for (int k = 0; k < 9 && n0 + k < mon_sym.size(); k++) begin
            checks++; if (mon_sym[n0+k] !== tx_syms[k] || mon_last[n0+k] !== (k == 8)) begin failures++; $display("FAIL gap_rx k=%0d sym=%0h last=%0b exp=%0h/%0b", k, mon_sym[n0+k], mon_last[n0+k], tx_syms[k], (k == 8)); end
        end
        checks++; if (cw_count_a !== 16'd1) begin failures++; $display("FAIL gap_cw_count got=%0d exp=1", cw_count_a); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_err_window();
        test_long_codeword();
        test_reset_mid();
        test_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
